// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the ALU
// write-back path and the multi-cycle MDU/LSU write-back path.
//  - Combinational grant. ARB_MODE=0 is round-robin: a 1-bit pointer favours
//    the loser of the last contended cycle. ARB_MODE=1 is fixed priority:
//    the ALU always wins.
//  - The winning write is registered onto rf_wen/rf_waddr/rf_wdata one cycle
//    after it is accepted. A write to x0 is accepted but never enables the
//    register file.
//  - A 32-entry pending-write scoreboard (busy) lets decode detect RAW/WAW
//    hazards. Set is requested by decode; clear happens when the register
//    file writes. If both happen to the same index in one cycle, set wins.
// Optional feature: define RF_WB_STAT_EN to add the conflict_cnt output, a
// free-running count of cycles in which both sources request.
module rf_wb_arbiter #(
  parameter int XLEN     = 64,
  parameter int ARB_MODE = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  input  logic            set_en,
  input  logic [4:0]      set_rd,
  output logic [31:0]     busy,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
`ifdef RF_WB_STAT_EN
  ,
  output logic [31:0]     conflict_cnt
`endif
);

  localparam bit FIXED_PRIO = (ARB_MODE != 0);

  // Pointer: 0 favours the ALU, 1 favours the MDU/LSU on the next contention.
  logic            ptr_q, ptr_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic            both_valid;
  logic            alu_pick;
  logic            xfer;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // Grant: the ALU wins when it is the only requester, or when it contends
  // and either fixed priority is on or the pointer favours it. No request is
  // accepted while reset is asserted.
  always_comb begin
    both_valid = alu_valid && mdu_valid;
    alu_pick   = alu_valid && (!mdu_valid || FIXED_PRIO || !ptr_q);
    alu_ready  = alu_pick && !reset;
    mdu_ready  = mdu_valid && !alu_pick && !reset;
  end

  // Next state: select the accepted write and flip the pointer toward the loser.
  always_comb begin
    xfer       = alu_ready || mdu_ready;
    wb_rd      = alu_ready ? alu_rd : mdu_rd;
    wb_data    = alu_ready ? alu_data : mdu_data;
    rf_wen_d   = xfer && (wb_rd != 5'd0);
    rf_waddr_d = xfer ? wb_rd : rf_waddr_q;
    rf_wdata_d = xfer ? wb_data : rf_wdata_q;
    ptr_d      = ptr_q;
    if (both_valid && xfer) begin
      ptr_d = alu_ready;
    end
  end

  // Scoreboard next state, one bit per register; x0 is never pending.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_bit
        assign busy_d[gi] = (set_en && (set_rd == 5'(gi))) ||
                            (busy_q[gi] && !(rf_wen_q && (rf_waddr_q == 5'(gi))));
      end
    end
  endgenerate

  // State registers; reset drops any registered write and clears the scoreboard.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      busy_q     <= 32'd0;
    end else begin
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

`ifdef RF_WB_STAT_EN
  logic [31:0] conflict_cnt_q;

  // Contention counter: counts every cycle both sources request; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_cnt_q <= 32'd0;
    end else if (alu_valid && mdu_valid) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single 64-bit register-file write port between two write-back sources: the ALU pipeline and the multi-cycle MDU/LSU path.
- Arbitrates with a valid/ready handshake and registers the winning write onto the register-file port.
- Keeps a 32-entry pending-write scoreboard so decode can detect RAW/WAW hazards against in-flight destinations.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 64, data width of write-back data and register-file write data
- ARB_MODE, 0, 0 = round-robin between sources; 1 = fixed priority, ALU always wins

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- mdu_valid  in  1  MDU/LSU write-back request
- mdu_ready  out  1  MDU/LSU request accepted this cycle
- mdu_rd  in  5  MDU/LSU destination register
- mdu_data  in  XLEN  MDU/LSU result
- set_en  in  1  decode issues an instruction with destination set_rd
- set_rd  in  5  destination to mark pending
- busy  out  32  scoreboard; bit i = write to xi pending
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data

Behaviour:
- Grant is combinational. ready is asserted only to the granted source, and only while that source's valid is high. A transfer occurs when valid && ready.
- Only one source valid: that source is granted.
- Both sources valid:
  - ARB_MODE=1: ALU is granted.
  - ARB_MODE=0: a 1-bit pointer decides. The pointer resets to favour the ALU.
  - After any both-valid grant, the pointer flips to favour the loser, so a waiting source waits at most 1 cycle.
  - A single-valid grant does not change the pointer.
- Requesters hold valid/rd/data stable until they see ready.
- Output register:
  - A transfer accepted in cycle N drives rf_waddr/rf_wdata in cycle N+1.
  - rf_wen=1 in N+1 only if rd != 0. A write to x0 is accepted (ready asserted) but produces rf_wen=0.
  - With no transfer, rf_wen=0 next cycle; rf_waddr/rf_wdata hold their last value.
- The register file samples rf_wen/rf_waddr/rf_wdata at the end of cycle N+1. Total latency from accept to architectural update is 1 cycle.
- Scoreboard:
  - Set: set_en=1 with set_rd != 0 sets busy[set_rd] at the next edge.
  - Clear: rf_wen=1 clears busy[rf_waddr] at the same edge the register file writes.
  - Set and clear of the same index in the same cycle: set wins (a new producer was issued).
  - Set on an already-busy bit: the bit stays 1. There is no count; decode stalls on busy, so at most one outstanding producer per register.
  - busy[0] is hard-wired 0.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, pointer=ALU, alu_ready/mdu_ready follow valid per the rules above.
- Reset mid-operation: a registered pending write is dropped (rf_wen=0 the cycle after reset is sampled) and all busy bits clear. Requests presented during reset are not accepted: ready=0 while reset=1.

Optional Feature:
- Macro RF_WB_STAT_EN.
- Defined:
  - Adds output conflict_cnt (out, 32): a counter that increments on every cycle with alu_valid && mdu_valid while not in reset.
  - Resets to 0 and wraps from 0xFFFFFFFF to 0.
- Undefined: no port, no counter; all other behaviour is identical.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0x1234 in cycle N -> alu_ready=1 in N; rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in N+1; rf_wen=0 in N+2.
- Contention with ARB_MODE=0 after reset: both valid, alu_rd=3, mdu_rd=4, each held until ready.
  - ALU granted in N, MDU granted in N+1.
  - rf_waddr is 3 in N+1 and 4 in N+2.
  - A second contention then grants MDU first.
  - With ARB_MODE=1, ALU wins every both-valid cycle.
- x0 write: mdu_valid=1, mdu_rd=0, mdu_data=0xFFFF -> mdu_ready=1; rf_wen stays 0; busy stays 0.
- Scoreboard:
  - set_en with set_rd=7 -> busy=0x80.
  - Later ALU write to rd=7 -> busy[7] clears at the edge where rf_wen=1.
  - set_en set_rd=7 in the same cycle as rf_wen to 7 -> busy[7] remains 1.
- Reset mid-operation: accept an ALU write to rd=9 and set busy[9], then assert reset in the cycle the write is on the port -> rf_wen=0 after reset, busy=0, ready=0 during reset.
- With RF_WB_STAT_EN: 3 cycles of both-valid and 2 cycles of single-valid -> conflict_cnt=3.
